regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
- Write-port scheduler and scoreboard in front of the single-write-port register file.
- Arbitrates round-robin among NREQ writeback requesters (ALU, LSU, MDU), one write per cycle, and drives the registered rd_we/rd_idx/rd_data port.
- Holds a 32-bit busy scoreboard, set at issue and cleared at writeback acceptance, and gives decode a combinational RAW/WAW stall.

Parameters:
NREQ, 3, number of writeback requesters (2..4); index 0 = ALU, 1 = LSU, 2 = MDU
XLEN, 32, data width

Ports:
clk_sys  input  1  system clock
rst_sys  input  1  asynchronous, active-low reset
i_pip_flush  input  1  pipeline flush, synchronous
iss_valid  input  1  instruction issued this cycle with a destination register
iss_rd_idx  input  5  destination of the issued instruction
hz_rs1_idx  input  5  decode source 1 to check
hz_rs2_idx  input  5  decode source 2 to check
hz_rd_idx  input  5  decode destination to check
hz_stall  output  1  combinational: any checked index is busy
req_valid  input  NREQ  writeback request per requester
req_ready  output  NREQ  grant; transfer when valid&&ready
req_rd_idx  input  5*NREQ  packed destination, requester i at [5i+4:5i]
req_data  input  XLEN*NREQ  packed data
rf_we  output  1  to regfile rd_we
rf_rd_idx  output  5  to regfile rd_idx
rf_rd_data  output  XLEN  to regfile rd_data
busy_vec  output  32  scoreboard (debug / CSR visibility)
stat_wb_cnt  output  32  accepted writebacks (optional feature)
stat_conflict_cnt  output  32  cycles with >1 req_valid (optional feature)

Behaviour:
- Reset (rst_sys low, asynchronous):
  - rf_we=0, rf_rd_idx=0, rf_rd_data=0.
  - busy_vec=0, rr_ptr=0, stat counters=0.
- Arbitration:
  - Combinational round-robin. Search starts at rr_ptr and wraps modulo NREQ.
  - The first valid requester found gets req_ready=1. At most one ready bit is set.
  - req_ready never depends on the requester's own ready; it depends only on req_valid and rr_ptr.
- On grant to requester g (posedge):
  - rr_ptr <= (g+1) mod NREQ.
  - rf_we <= (idx != 0), rf_rd_idx <= idx, rf_rd_data <= data.
  - Latency: exactly 1 cycle from acceptance to rf_we. rf_we is a single-cycle pulse per accepted request.
  - Back-to-back grants produce rf_we on consecutive cycles.
- No valid request: rf_we <= 0. rf_rd_idx/rf_rd_data hold their previous values. rr_ptr unchanged.
- x0:
  - A request with idx 0 is accepted (handshake completes) but produces rf_we=0.
  - busy_vec[0] is constant 0.
- Scoreboard:
  - Set busy[iss_rd_idx] on iss_valid when idx != 0.
  - Clear busy[idx] at acceptance of a request to idx.
  - The regfile's write-cycle bypass covers the following cycle, so no extra stall is needed.
- Simultaneous set and clear of the same idx: set wins, because a newer producer was issued.
- hz_stall = busy[hz_rs1_idx] | busy[hz_rs2_idx] | busy[hz_rd_idx]. Index 0 never stalls.
- Flush (i_pip_flush=1):
  - req_ready=0 for all requesters; no grant that cycle.
  - Next cycle: busy_vec=0, rf_we=0; issue in the flush cycle is ignored; rr_ptr unchanged.
  - A write already registered (rf_we=1 during the flush cycle) still completes.
  - Requesters squash their own in-flight ops on flush.
- Request with valid high and not granted: the requester holds idx and data stable until granted.

Optional Feature:
- Macro RF_WB_STATS_EN.
- Defined:
  - stat_wb_cnt increments on every accepted request, including idx 0.
  - stat_conflict_cnt increments on every non-flush cycle with popcount(req_valid) > 1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset mid-operation: assert rst_sys low while rf_we=1 and busy_vec=0x0000_0024 -> rf_we, busy_vec and rr_ptr read 0 immediately, before any clock edge.
- Single write: iss x5, then ALU valid {5, 0xDEADBEEF} -> req_ready[0]=1; next cycle rf_we=1, rf_rd_idx=5, rf_rd_data=0xDEADBEEF, busy[5]=0; hz_stall with hz_rs1_idx=5 is 1 before acceptance and 0 from the next cycle.
- Three requesters valid for 6 cycles with rr_ptr=0 -> grants in order 0,1,2,0,1,2; rf_we high for 6 consecutive cycles; stat_conflict_cnt increases for every cycle with >1 valid (feature on).
- Same cycle: iss_valid x7 and LSU writeback to x7 accepted -> busy[7] stays 1; rf_we=1 for x7 on the next cycle.
- Write to x0: ALU valid {0, 0x1234} -> handshake completes, rf_we stays 0, busy_vec unchanged.
- Flush with busy_vec=0x0000_00A0, LSU valid and iss_valid x3 -> req_ready=0 that cycle; next cycle busy_vec=0 and rf_we=0; the LSU request is granted once flush deasserts.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Writeback request bus between the requesters (ALU, LSU, MDU, ...) and regfile_wb_sched.
//   req_valid  : one request bit per requester
//   req_ready  : grant back to each requester; a transfer happens when valid && ready
//   req_rd_idx : packed destinations, requester i at [5i+4:5i]
//   req_data   : packed write data, requester i at [XLEN*i +: XLEN]
// master = requester side, slave = scheduler side.
interface regfile_wb_sched_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_rd_idx;
  logic [XLEN*NREQ-1:0] req_data;

  modport master (output req_valid, output req_rd_idx, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rd_idx, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and busy scoreboard in front of the single-write-port register file.
// Round-robin arbitration among NREQ writeback requesters, one registered write per cycle,
// plus a 32-entry busy scoreboard giving decode a combinational RAW/WAW stall.
// Optional statistics counters are built when the macro RF_WB_STATS_EN is defined.
// Ports:
//   clk_sys, rst_sys (async, active-low)   clock / reset
//   i_pip_flush                            synchronous pipeline flush
//   iss_valid, iss_rd_idx                  issue of an instruction with a destination
//   hz_rs1_idx, hz_rs2_idx, hz_rd_idx      decode indices to check; hz_stall (combinational)
//   wb (regfile_wb_sched_if.slave)         writeback request/grant bus
//   rf_we, rf_rd_idx, rf_rd_data           registered regfile write port
//   busy_vec                               scoreboard view
//   stat_wb_cnt, stat_conflict_cnt         accepted writebacks / multi-request cycles
module regfile_wb_sched #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  input  logic                  i_pip_flush,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd_idx,
  input  logic [4:0]            hz_rs1_idx,
  input  logic [4:0]            hz_rs2_idx,
  input  logic [4:0]            hz_rd_idx,
  output logic                  hz_stall,
  regfile_wb_sched_if.slave     wb,
  output logic                  rf_we,
  output logic [4:0]            rf_rd_idx,
  output logic [XLEN-1:0]       rf_rd_data,
  output logic [31:0]           busy_vec,
  output logic [31:0]           stat_wb_cnt,
  output logic [31:0]           stat_conflict_cnt
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;

  logic             grant_c;
  logic [PTR_W-1:0] gnt_idx_c;
  logic [NREQ-1:0]  ready_c;
  logic [IDX_W-1:0] gnt_rd_c;
  logic [XLEN-1:0]  gnt_data_c;
  int unsigned      cand_sum;
  logic [PTR_W-1:0] cand_idx;

  // Unpack the requester lanes
  logic [IDX_W-1:0] rd_lane   [NREQ];
  logic [XLEN-1:0]  data_lane [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign rd_lane[g]   = wb.req_rd_idx[g*IDX_W +: IDX_W];
    assign data_lane[g] = wb.req_data[g*XLEN +: XLEN];
  end

  // Round-robin search starting at rr_ptr; flush blocks every grant
  always_comb begin : arb
    grant_c   = 1'b0;
    gnt_idx_c = '0;
    ready_c   = '0;
    cand_sum  = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_sum = 32'(rr_ptr) + k;
      if (cand_sum >= NREQ) cand_sum = cand_sum - NREQ;
      cand_idx = PTR_W'(cand_sum);
      if (!grant_c && !i_pip_flush && wb.req_valid[cand_idx]) begin
        grant_c           = 1'b1;
        gnt_idx_c         = cand_idx;
        ready_c[cand_idx] = 1'b1;
      end
    end
    gnt_rd_c   = rd_lane[gnt_idx_c];
    gnt_data_c = data_lane[gnt_idx_c];
  end

  assign wb.req_ready = ready_c;

  // Pointer moves past the winner only when a grant happens
  always_comb begin : rr_next
    rr_ptr_d = rr_ptr;
    if (grant_c) begin
      rr_ptr_d = (gnt_idx_c == PTR_W'(NREQ - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
    end
  end

  // Scoreboard: clear on acceptance, then set on issue so a newer producer wins
  always_comb begin : sb_next
    busy_d = busy_q;
    if (i_pip_flush) begin
      busy_d = '0;
    end else begin
      if (grant_c)   busy_d[gnt_rd_c]   = 1'b0;
      if (iss_valid) busy_d[iss_rd_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin : regs
    if (!rst_sys) begin
      rr_ptr     <= '0;
      busy_q     <= '0;
      rf_we      <= 1'b0;
      rf_rd_idx  <= '0;
      rf_rd_data <= '0;
    end else begin
      rr_ptr <= rr_ptr_d;
      busy_q <= busy_d;
      rf_we  <= grant_c && (gnt_rd_c != '0);
      if (grant_c) begin
        rf_rd_idx  <= gnt_rd_c;
        rf_rd_data <= gnt_data_c;
      end
    end
  end

  assign busy_vec = busy_q;
  assign hz_stall = busy_q[hz_rs1_idx] | busy_q[hz_rs2_idx] | busy_q[hz_rd_idx];

`ifdef RF_WB_STATS_EN
  logic [31:0] wb_cnt_q;
  logic [31:0] conflict_cnt_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk_sys or negedge rst_sys) begin : stats
    if (!rst_sys) begin
      wb_cnt_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (grant_c) wb_cnt_q <= wb_cnt_q + 32'd1;
      if (!i_pip_flush && ($countones(wb.req_valid) > 1)) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign stat_wb_cnt       = wb_cnt_q;
  assign stat_conflict_cnt = conflict_cnt_q;
`else
  assign stat_wb_cnt       = '0;
  assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (NREQ=3, XLEN=32).
module tb_regfile_wb_sched;

  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NVEC = 17;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        i_pip_flush;
  logic        iss_valid;
  logic [4:0]  iss_rd_idx;
  logic [4:0]  hz_rs1_idx;
  logic [4:0]  hz_rs2_idx;
  logic [4:0]  hz_rd_idx;
  logic        hz_stall;
  logic        rf_we;
  logic [4:0]  rf_rd_idx;
  logic [31:0] rf_rd_data;
  logic [31:0] busy_vec;
  logic [31:0] stat_wb_cnt;
  logic [31:0] stat_conflict_cnt;

  regfile_wb_sched_if #(.NREQ(NREQ), .XLEN(XLEN)) wb_if ();

  regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk_sys           (clk_sys),
    .rst_sys           (rst_sys),
    .i_pip_flush       (i_pip_flush),
    .iss_valid         (iss_valid),
    .iss_rd_idx        (iss_rd_idx),
    .hz_rs1_idx        (hz_rs1_idx),
    .hz_rs2_idx        (hz_rs2_idx),
    .hz_rd_idx         (hz_rd_idx),
    .hz_stall          (hz_stall),
    .wb                (wb_if),
    .rf_we             (rf_we),
    .rf_rd_idx         (rf_rd_idx),
    .rf_rd_data        (rf_rd_data),
    .busy_vec          (busy_vec),
    .stat_wb_cnt       (stat_wb_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        flush;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  vld;
    logic [4:0]  i0;
    logic [4:0]  i1;
    logic [4:0]  i2;
    logic [2:0]  e_rdy;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_idx;
    logic [31:0] e_busy;
  } vec_t;

  vec_t        vec [NVEC];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_data;

  function automatic logic [31:0] mkdata(input int n, input int r);
    return 32'hA500_0000 | (32'(n) << 8) | 32'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int n);
    i_pip_flush       = v.flush;
    iss_valid         = v.iss_v;
    iss_rd_idx        = v.iss_rd;
    hz_rs1_idx        = v.rs1;
    hz_rs2_idx        = v.rs2;
    hz_rd_idx         = v.rd;
    wb_if.req_valid   = v.vld;
    wb_if.req_rd_idx  = {v.i2, v.i1, v.i0};
    wb_if.req_data    = {mkdata(n, 2), mkdata(n, 1), mkdata(n, 0)};
  endtask

  initial begin
    //               flush iss  rd  rs1 rs2 rd  vld     i0 i1 i2  e_rdy  stl we idx busy
    vec[0]  = '{1'b0, 1'b1, 5, 5, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1'b0, 1'b0, 0, 32'h20};
    vec[1]  = '{1'b0, 1'b0, 0, 5, 0, 0, 3'b001, 5, 0, 0, 3'b001, 1'b1, 1'b1, 5, 32'h00};
    vec[2]  = '{1'b0, 1'b0, 0, 5, 0, 0, 3'b100, 0, 0, 9, 3'b100, 1'b0, 1'b1, 9, 32'h00};
    vec[3]  = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b111, 1, 2, 3, 3'b001, 1'b0, 1'b1, 1, 32'h00};
    vec[4]  = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b111, 1, 2, 3, 3'b010, 1'b0, 1'b1, 2, 32'h00};
    vec[5]  = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b111, 1, 2, 3, 3'b100, 1'b0, 1'b1, 3, 32'h00};
    vec[6]  = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b111, 1, 2, 3, 3'b001, 1'b0, 1'b1, 1, 32'h00};
    vec[7]  = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b111, 1, 2, 3, 3'b010, 1'b0, 1'b1, 2, 32'h00};
    vec[8]  = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b111, 1, 2, 3, 3'b100, 1'b0, 1'b1, 3, 32'h00};
    vec[9]  = '{1'b0, 1'b1, 7, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1'b0, 1'b0, 3, 32'h80};
    vec[10] = '{1'b0, 1'b1, 7, 0, 7, 0, 3'b010, 0, 7, 0, 3'b010, 1'b1, 1'b1, 7, 32'h80};
    vec[11] = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 3'b001, 1'b0, 1'b0, 0, 32'h80};
    vec[12] = '{1'b0, 1'b1, 5, 0, 0, 7, 3'b000, 0, 0, 0, 3'b000, 1'b1, 1'b0, 0, 32'hA0};
    vec[13] = '{1'b1, 1'b1, 3, 5, 0, 0, 3'b010, 0, 4, 0, 3'b000, 1'b1, 1'b0, 0, 32'h00};
    vec[14] = '{1'b0, 1'b0, 0, 3, 0, 0, 3'b010, 0, 4, 0, 3'b010, 1'b0, 1'b1, 4, 32'h00};
    vec[15] = '{1'b1, 1'b0, 0, 0, 0, 0, 3'b001, 6, 0, 0, 3'b000, 1'b0, 1'b0, 4, 32'h00};
    vec[16] = '{1'b0, 1'b0, 0, 0, 0, 0, 3'b001, 6, 0, 0, 3'b001, 1'b0, 1'b1, 6, 32'h00};

    exp_data    = 32'h0;
    rst_sys     = 1'b0;
    i_pip_flush = 1'b0;
    iss_valid   = 1'b0;
    iss_rd_idx  = '0;
    hz_rs1_idx  = '0;
    hz_rs2_idx  = '0;
    hz_rd_idx   = '0;
    wb_if.req_valid  = '0;
    wb_if.req_rd_idx = '0;
    wb_if.req_data   = '0;

    // Reset state
    #1;
    check("reset_rf_we", 32'(rf_we), 32'h0);
    check("reset_rf_rd_idx", 32'(rf_rd_idx), 32'h0);
    check("reset_rf_rd_data", rf_rd_data, 32'h0);
    check("reset_busy_vec", busy_vec, 32'h0);
    check("reset_stat_wb", stat_wb_cnt, 32'h0);
    check("reset_stat_conflict", stat_conflict_cnt, 32'h0);
    check("reset_ready", 32'(wb_if.req_ready), 32'h0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_sys = 1'b1;

    // Directed vector table
    for (int n = 0; n < int'(NVEC); n++) begin
      @(negedge clk_sys);
      drive(vec[n], n);
      #1;
      check($sformatf("v%0d_ready", n), 32'(wb_if.req_ready), 32'(vec[n].e_rdy));
      check($sformatf("v%0d_hz_stall", n), 32'(hz_stall), 32'(vec[n].e_stall));
      if (vec[n].e_rdy[0])      exp_data = mkdata(n, 0);
      else if (vec[n].e_rdy[1]) exp_data = mkdata(n, 1);
      else if (vec[n].e_rdy[2]) exp_data = mkdata(n, 2);
      @(posedge clk_sys);
      #1;
      check($sformatf("v%0d_rf_we", n), 32'(rf_we), 32'(vec[n].e_we));
      check($sformatf("v%0d_rf_rd_idx", n), 32'(rf_rd_idx), 32'(vec[n].e_idx));
      check($sformatf("v%0d_rf_rd_data", n), rf_rd_data, exp_data);
      check($sformatf("v%0d_busy_vec", n), busy_vec, vec[n].e_busy);
    end

`ifdef RF_WB_STATS_EN
    check("stat_wb_cnt", stat_wb_cnt, 32'd12);
    check("stat_conflict_cnt", stat_conflict_cnt, 32'd6);
`else
    check("stat_wb_cnt_tied", stat_wb_cnt, 32'd0);
    check("stat_conflict_cnt_tied", stat_conflict_cnt, 32'd0);
`endif

    // Asynchronous reset in the middle of a write with x2/x5 busy
    @(negedge clk_sys);
    i_pip_flush      = 1'b0;
    iss_valid        = 1'b1;
    iss_rd_idx       = 5'd2;
    wb_if.req_valid  = 3'b000;
    @(negedge clk_sys);
    iss_rd_idx       = 5'd5;
    wb_if.req_valid  = 3'b001;
    wb_if.req_rd_idx = {5'd0, 5'd0, 5'd9};
    @(posedge clk_sys);
    #1;
    check("pre_rst_rf_we", 32'(rf_we), 32'h1);
    check("pre_rst_busy_vec", busy_vec, 32'h24);
    check("pre_rst_rr_ptr", 32'(dut.rr_ptr), 32'h1);
    #2;
    rst_sys = 1'b0;
    #1;
    check("async_rst_rf_we", 32'(rf_we), 32'h0);
    check("async_rst_busy_vec", busy_vec, 32'h0);
    check("async_rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    check("async_rst_rf_rd_idx", 32'(rf_rd_idx), 32'h0);
    check("async_rst_stat_wb", stat_wb_cnt, 32'h0);
    @(negedge clk_sys);
    iss_valid       = 1'b0;
    wb_if.req_valid = 3'b000;
    rst_sys         = 1'b1;
    @(negedge clk_sys);
    wb_if.req_valid  = 3'b111;
    wb_if.req_rd_idx = {5'd3, 5'd2, 5'd1};
    #1;
    check("post_rst_ready", 32'(wb_if.req_ready), 32'h1);
    @(posedge clk_sys);
    #1;
    check("post_rst_rf_we", 32'(rf_we), 32'h1);
    check("post_rst_rf_rd_idx", 32'(rf_rd_idx), 32'h1);
    @(negedge clk_sys);
    wb_if.req_valid = 3'b000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
